// File: rtl/diy_pkg.sv
// Shared constants for the DIY mole scheduler: mode encodings, entry layout
// and default sizing.
package diy_pkg;

    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 23;
    localparam int unsigned LOC_W      = 3;
    localparam int unsigned ENTRY_W    = ADDR_W_DEF + LOC_W;

    localparam logic [ADDR_W_DEF-1:0] MIN_GAP_DEF = 23'h2000;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_RECORD = 2'd1;
    localparam logic [1:0] MODE_PLAY   = 2'd2;

endpackage

// File: rtl/diy_mole_store.sv
// Entry register file: synchronous write, asynchronous read. Contents are not
// reset; only entries below the scheduler's count are ever read meaningfully.
module diy_mole_store #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 26
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/diy_mole_scheduler.sv
// Records stomped pad locations against music addresses in DIY mode and
// replays them as single-cycle mole requests when the music reaches them.
module diy_mole_scheduler
    import diy_pkg::*;
#(
    parameter int unsigned        DEPTH   = DEPTH_DEF,
    parameter int unsigned        ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0]  MIN_GAP = MIN_GAP_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     record_start,
    input  logic                     record_stop,
    input  logic                     play_start,
    input  logic                     stomp,
    input  logic [2:0]               stomp_location,
    input  logic [ADDR_W-1:0]        music_address,
    output logic                     request_mole,
    output logic [2:0]               mole_location,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [1:0]               mode
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned ENT_W = ADDR_W + LOC_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_req;
    logic [2:0]        r_loc;

    logic [ENT_W-1:0]  w_wr_data;
    logic [ENT_W-1:0]  w_rd_entry;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [2:0]        w_rd_loc;
    logic [ADDR_W:0]   w_gap_sum;
    logic              w_gap_ok;
    logic              w_accept;
    logic              w_match;
    logic [CNT_W-1:0]  w_rd_next;
    logic              w_stop_cmd;
    logic              w_play_cmd;

    always_comb begin
        w_wr_data  = {music_address, stomp_location};
        w_rd_addr  = w_rd_entry[ENT_W-1:LOC_W];
        w_rd_loc   = w_rd_entry[LOC_W-1:0];
        // One extra bit so last_addr + MIN_GAP near the top of the range
        // cannot wrap and falsely admit a stomp.
        w_gap_sum  = {1'b0, r_last_addr} + {1'b0, MIN_GAP};
        w_gap_ok   = (r_count == '0) || ({1'b0, music_address} >= w_gap_sum);
        w_accept   = (r_mode == MODE_RECORD) && stomp
                     && (r_count < CNT_FULL) && w_gap_ok;
        w_match    = (r_mode == MODE_PLAY) && (r_rd_ptr < r_count)
                     && (music_address >= w_rd_addr);
        w_rd_next  = r_rd_ptr + CNT_ONE;
        w_stop_cmd = record_stop && (r_mode == MODE_RECORD);
        w_play_cmd = play_start && (r_mode != MODE_RECORD);
    end

    diy_mole_store #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_store (
        .i_clk   (clk),
        .i_we    (w_accept && !reset && !record_stop && !record_start && !w_play_cmd),
        .i_waddr (r_count[IDX_W-1:0]),
        .i_wdata (w_wr_data),
        .i_raddr (r_rd_ptr[IDX_W-1:0]),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= MODE_IDLE;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_last_addr <= '0;
            r_req       <= 1'b0;
            r_loc       <= '0;
        end else begin
            r_req <= 1'b0;
            if (w_stop_cmd) begin
                r_mode <= MODE_IDLE;
            end else if (record_start) begin
                r_count <= '0;
                r_mode  <= MODE_RECORD;
            end else if (w_play_cmd) begin
                r_rd_ptr <= '0;
                r_mode   <= (r_count == '0) ? MODE_IDLE : MODE_PLAY;
            end else begin
                if (w_accept) begin
                    r_count     <= r_count + CNT_ONE;
                    r_last_addr <= music_address;
                end
                if (w_match) begin
                    r_req    <= 1'b1;
                    r_loc    <= w_rd_loc;
                    r_rd_ptr <= w_rd_next;
                    if (w_rd_next == r_count) begin
                        r_mode <= MODE_IDLE;
                    end
                end
            end
        end
    end

    assign request_mole  = r_req;
    assign mole_location = r_loc;
    assign count         = r_count;
    assign full          = (r_count == CNT_FULL);
    assign mode          = r_mode;

endmodule
